// File: rtl/dcache_pkg.sv
// ----------------------------------------------------------------------------
// dcache_pkg
//   Shared types and constants for the data cache.
//   - Address decomposition (tag/idx/blkoff/bytoff) for a 2-way, 8-set,
//     2-word-block cache on a 32-bit word-addressed bus.
//   - Frame layout (valid, dirty, tag, two data words).
//   - Controller state encoding.
//   - blockAddr(): rebuilds a memory word address from a frame's tag/set/word.
// ----------------------------------------------------------------------------
package dcache_pkg;

  localparam int SETS  = 8;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 3;
  // Flush frame counter walks every frame of both ways: one extra bit for the way.
  localparam int FI_W  = IDX_W + 1;

  localparam logic [31:0] DEF_HITCNT_ADDR = 32'h0000_3100;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic             blkoff;
    logic [1:0]       bytoff;
  } dcachef_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    logic [1:0][31:0] data;
  } dcache_frame_t;

  typedef enum logic [3:0] {
    IDLE,
    WB0,
    WB1,
    LD0,
    LD1,
    FL_CHK,
    FL_WB0,
    FL_WB1,
    CNT,
    DONE
  } dstate_t;

  function automatic logic [31:0] blockAddr(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx,
                                            input logic             word);
    return {tag, idx, word, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_store.sv
// ----------------------------------------------------------------------------
// dcache_store
//   Frame array (2 ways x SETS) plus one LRU bit per set.
//   Ports:
//     i_clk, i_rst_n      clock, async active-low reset (clears valid/dirty/LRU)
//     i_idx               set index used for both the read and the write port
//     o_way0, o_way1      combinational read of both frames at i_idx
//     o_lru               LRU bit at i_idx (the way to evict next)
//     i_wrEn/i_wrWay/i_wrWord/i_wrData   single data-word write
//     i_setDirty/i_clrDirty              dirty bit update of frame i_wrWay
//     i_fill/i_fillTag                   mark frame i_wrWay valid+clean with tag
//     i_lruWe/i_lruVal                   LRU bit update at i_idx
// ----------------------------------------------------------------------------
module dcache_store
  import dcache_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IDX_W-1:0] i_idx,
  output dcache_frame_t    o_way0,
  output dcache_frame_t    o_way1,
  output logic             o_lru,
  input  logic             i_wrEn,
  input  logic             i_wrWay,
  input  logic             i_wrWord,
  input  logic [31:0]      i_wrData,
  input  logic             i_setDirty,
  input  logic             i_clrDirty,
  input  logic             i_fill,
  input  logic [TAG_W-1:0] i_fillTag,
  input  logic             i_lruWe,
  input  logic             i_lruVal
);

  dcache_frame_t   r_frames [2][SETS];
  logic [SETS-1:0] r_lru;

  assign o_way0 = r_frames[0][i_idx];
  assign o_way1 = r_frames[1][i_idx];
  assign o_lru  = r_lru[i_idx];

  // All metadata and data updates target the same (way, set); a fill may
  // coincide with the final data-word write of a line load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < SETS; s++) begin
          r_frames[w][s] <= '0;
        end
      end
      r_lru <= '0;
    end else begin
      if (i_wrEn) begin
        r_frames[i_wrWay][i_idx].data[i_wrWord] <= i_wrData;
      end
      if (i_setDirty) begin
        r_frames[i_wrWay][i_idx].dirty <= 1'b1;
      end
      if (i_clrDirty) begin
        r_frames[i_wrWay][i_idx].dirty <= 1'b0;
      end
      if (i_fill) begin
        r_frames[i_wrWay][i_idx].valid <= 1'b1;
        r_frames[i_wrWay][i_idx].dirty <= 1'b0;
        r_frames[i_wrWay][i_idx].tag   <= i_fillTag;
      end
      if (i_lruWe) begin
        r_lru[i_idx] <= i_lruVal;
      end
    end
  end

endmodule

// File: rtl/dcache.sv
// ----------------------------------------------------------------------------
// dcache
//   2-way set-associative write-back/write-allocate data cache.
//   Datapath side: i_dmemREN/i_dmemWEN/i_dmemaddr/i_dmemstore requests,
//     o_dhit/o_dmemload responses (same-cycle on hit), i_halt starts a flush,
//     o_flushed reports flush plus hit-count store complete.
//   Memory side: o_dREN/o_dWEN/o_daddr/o_dstore requests, i_dwait busy,
//     i_dload read data; a transfer completes in the first cycle i_dwait=0.
//   i_clk / i_rst_n: clock and async active-low reset.
// ----------------------------------------------------------------------------
module dcache
  import dcache_pkg::*;
#(
  parameter logic [31:0] HITCNT_ADDR = DEF_HITCNT_ADDR
)
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_halt,
  input  logic        i_dmemREN,
  input  logic        i_dmemWEN,
  input  logic [31:0] i_dmemaddr,
  input  logic [31:0] i_dmemstore,
  output logic        o_dhit,
  output logic [31:0] o_dmemload,
  output logic        o_flushed,
  output logic        o_dREN,
  output logic        o_dWEN,
  output logic [31:0] o_daddr,
  output logic [31:0] o_dstore,
  input  logic        i_dwait,
  input  logic [31:0] i_dload
);

  dstate_t         r_state, w_nextState;
  logic [FI_W-1:0] r_fi;
  logic [31:0]     r_hitCnt;
  logic            r_missFlag;

  dcachef_t         w_req;
  logic             w_unusedBytoff;
  logic             w_flushing;
  logic [IDX_W-1:0] w_idx;
  dcache_frame_t    w_way0, w_way1, w_victim, w_flFrame;
  logic             w_lru;
  logic             w_hit0, w_hit1, w_hit, w_hitWay, w_anyReq, w_dhit;
  logic             w_flDirty, w_fiLast;
  logic [31:0]      w_hitWord;

  logic             w_wrEn, w_wrWay, w_wrWord, w_setDirty, w_clrDirty, w_fill;
  logic             w_lruWe, w_lruVal;
  logic [31:0]      w_wrData;

  assign w_req          = dcachef_t'(i_dmemaddr);
  assign w_unusedBytoff = ^w_req.bytoff;

  // During flush the store is indexed by the frame counter instead of the request.
  assign w_flushing = (r_state == FL_CHK) || (r_state == FL_WB0) || (r_state == FL_WB1);
  assign w_idx      = w_flushing ? r_fi[IDX_W-1:0] : w_req.idx;

  assign w_hit0    = w_way0.valid && (w_way0.tag == w_req.tag);
  assign w_hit1    = w_way1.valid && (w_way1.tag == w_req.tag);
  assign w_hit     = w_hit0 || w_hit1;
  assign w_hitWay  = w_hit1;
  assign w_hitWord = w_hitWay ? w_way1.data[w_req.blkoff] : w_way0.data[w_req.blkoff];
  assign w_anyReq  = i_dmemREN || i_dmemWEN;
  assign w_dhit    = (r_state == IDLE) && !i_halt && w_anyReq && w_hit;

  assign w_victim  = w_lru ? w_way1 : w_way0;
  assign w_flFrame = r_fi[FI_W-1] ? w_way1 : w_way0;
  assign w_flDirty = w_flFrame.valid && w_flFrame.dirty;
  assign w_fiLast  = (r_fi == {FI_W{1'b1}});

  dcache_store u_store (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_idx      (w_idx),
    .o_way0     (w_way0),
    .o_way1     (w_way1),
    .o_lru      (w_lru),
    .i_wrEn     (w_wrEn),
    .i_wrWay    (w_wrWay),
    .i_wrWord   (w_wrWord),
    .i_wrData   (w_wrData),
    .i_setDirty (w_setDirty),
    .i_clrDirty (w_clrDirty),
    .i_fill     (w_fill),
    .i_fillTag  (w_req.tag),
    .i_lruWe    (w_lruWe),
    .i_lruVal   (w_lruVal)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Hit counter, miss flag and flush frame counter. A hit that completes a
  // just-filled miss clears the flag instead of counting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hitCnt   <= '0;
      r_missFlag <= 1'b0;
      r_fi       <= '0;
    end else begin
      if (w_dhit) begin
        r_missFlag <= 1'b0;
        if (!r_missFlag) begin
          r_hitCnt <= r_hitCnt + 32'd1;
        end
      end else if ((r_state == LD1) && !i_dwait) begin
        r_missFlag <= 1'b1;
      end
      if (((r_state == FL_CHK) && !w_flDirty && !w_fiLast) ||
          ((r_state == FL_WB1) && !i_dwait && !w_fiLast)) begin
        r_fi <= r_fi + 1'b1;
      end
    end
  end

  // Next-state logic. Halt is only honoured in IDLE so an in-flight miss
  // always completes first.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_halt) begin
          w_nextState = FL_CHK;
        end else if (w_anyReq && !w_hit) begin
          w_nextState = (w_victim.valid && w_victim.dirty) ? WB0 : LD0;
        end
      end
      WB0:    if (!i_dwait) w_nextState = WB1;
      WB1:    if (!i_dwait) w_nextState = LD0;
      LD0:    if (!i_dwait) w_nextState = LD1;
      LD1:    if (!i_dwait) w_nextState = IDLE;
      FL_CHK: begin
        if (w_flDirty) begin
          w_nextState = FL_WB0;
        end else if (w_fiLast) begin
          w_nextState = CNT;
        end
      end
      FL_WB0: if (!i_dwait) w_nextState = FL_WB1;
      FL_WB1: if (!i_dwait) w_nextState = w_fiLast ? CNT : FL_CHK;
      CNT:    if (!i_dwait) w_nextState = DONE;
      DONE:   w_nextState = DONE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output and store-control logic.
  always_comb begin
    o_dhit     = w_dhit;
    o_dmemload = w_dhit ? w_hitWord : 32'd0;
    o_flushed  = (r_state == DONE);
    o_dREN     = 1'b0;
    o_dWEN     = 1'b0;
    o_daddr    = 32'd0;
    o_dstore   = 32'd0;
    w_wrEn     = 1'b0;
    w_wrWay    = 1'b0;
    w_wrWord   = 1'b0;
    w_wrData   = 32'd0;
    w_setDirty = 1'b0;
    w_clrDirty = 1'b0;
    w_fill     = 1'b0;
    w_lruWe    = 1'b0;
    w_lruVal   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_dhit) begin
          w_lruWe  = 1'b1;
          w_lruVal = ~w_hitWay;
          if (i_dmemWEN) begin
            w_wrEn     = 1'b1;
            w_wrWay    = w_hitWay;
            w_wrWord   = w_req.blkoff;
            w_wrData   = i_dmemstore;
            w_setDirty = 1'b1;
          end
        end
      end
      WB0, WB1: begin
        o_dWEN   = 1'b1;
        o_daddr  = blockAddr(w_victim.tag, w_req.idx, r_state == WB1);
        o_dstore = w_victim.data[r_state == WB1];
      end
      LD0, LD1: begin
        o_dREN  = 1'b1;
        o_daddr = blockAddr(w_req.tag, w_req.idx, r_state == LD1);
        if (!i_dwait) begin
          w_wrEn   = 1'b1;
          w_wrWay  = w_lru;
          w_wrWord = (r_state == LD1);
          w_wrData = i_dload;
          w_fill   = (r_state == LD1);
        end
      end
      FL_WB0, FL_WB1: begin
        o_dWEN   = 1'b1;
        o_daddr  = blockAddr(w_flFrame.tag, r_fi[IDX_W-1:0], r_state == FL_WB1);
        o_dstore = w_flFrame.data[r_state == FL_WB1];
        if ((r_state == FL_WB1) && !i_dwait) begin
          w_wrWay    = r_fi[FI_W-1];
          w_clrDirty = 1'b1;
        end
      end
      CNT: begin
        o_dWEN   = 1'b1;
        o_daddr  = HITCNT_ADDR;
        o_dstore = r_hitCnt;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// ----------------------------------------------------------------------------
// tb_dcache
//   Table-driven bench for dcache with a latency-2 memory responder. Each
//   request vector carries its expected response and the memory transfers it
//   must cause; those transfers go into a scoreboard queue and are popped as
//   the responder completes them. Hand-written sequences cover the flush and
//   reset-during-fill cases.
// ----------------------------------------------------------------------------
module tb_dcache;
  import dcache_pkg::*;

  localparam int MEM_LAT = 2;
  localparam int BUDGET  = 200;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } memop_t;

  typedef struct {
    bit               ren;
    bit               wen;
    logic [31:0]      addr;
    logic [31:0]      data;
    bit               expHit;
    logic [31:0]      expLoad;
    int               nOps;
    logic [3:0]       opWe;
    logic [3:0][31:0] opAddr;
    logic [3:0][31:0] opData;
  } vec_t;

  logic        clk, rst_n, halt, dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;
  logic        dwait;
  logic [31:0] dload;

  int checks = 0;
  int errors = 0;
  int waitCnt = 0;
  int expHitCnt = 0;

  memop_t      expOps[$];
  vec_t        vecs[$];
  logic [31:0] mem [logic [31:0]];

  dcache dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_halt      (halt),
    .i_dmemREN   (dmemREN),
    .i_dmemWEN   (dmemWEN),
    .i_dmemaddr  (dmemaddr),
    .i_dmemstore (dmemstore),
    .o_dhit      (dhit),
    .o_dmemload  (dmemload),
    .o_flushed   (flushed),
    .o_dREN      (dREN),
    .o_dWEN      (dWEN),
    .o_daddr     (daddr),
    .o_dstore    (dstore),
    .i_dwait     (dwait),
    .i_dload     (dload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] defData(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : defData(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pops the scoreboard when the memory model completes a transfer.
  task automatic checkMemOp(input logic we, input logic [31:0] a, input logic [31:0] d);
    memop_t e;
    checks++;
    if (expOps.size() == 0) begin
      errors++;
      $display("[TB] FAIL memop: unexpected we=%0b addr=%h data=%h", we, a, d);
    end else begin
      e = expOps.pop_front();
      if (e.we !== we || e.addr !== a || (we && e.data !== d)) begin
        errors++;
        $display("[TB] FAIL memop: got we=%0b addr=%h data=%h, expected we=%0b addr=%h data=%h",
                 we, a, d, e.we, e.addr, e.data);
      end
    end
  endtask

  // Memory responder: each transfer waits MEM_LAT busy cycles, then completes.
  always @(negedge clk) begin
    if (!rst_n) begin
      waitCnt = 0;
      dwait   = 1'b1;
    end else if (dREN || dWEN) begin
      if (waitCnt < MEM_LAT) begin
        waitCnt++;
        dwait = 1'b1;
      end else begin
        waitCnt = 0;
        dwait   = 1'b0;
        if (dWEN) mem[daddr] = dstore;
        else      dload = memRead(daddr);
        checkMemOp(dWEN, daddr, dstore);
      end
    end else begin
      waitCnt = 0;
      dwait   = 1'b1;
    end
  end

  task automatic addVec(input bit ren, input bit wen, input logic [31:0] a,
                        input logic [31:0] d, input bit expHit, input logic [31:0] expLoad);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = a; v.data = d;
    v.expHit = expHit; v.expLoad = expLoad;
    v.nOps = 0; v.opWe = '0; v.opAddr = '0; v.opData = '0;
    vecs.push_back(v);
  endtask

  task automatic addOp(input logic we, input logic [31:0] a, input logic [31:0] d);
    int   last;
    vec_t v;
    last = vecs.size() - 1;
    v = vecs[last];
    v.opWe[v.nOps]   = we;
    v.opAddr[v.nOps] = a;
    v.opData[v.nOps] = d;
    v.nOps++;
    vecs[last] = v;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".dhit"},     {31'd0, dhit},    32'd0);
    checkOutput({tag, ".dmemload"}, dmemload,         32'd0);
    checkOutput({tag, ".flushed"},  {31'd0, flushed}, 32'd0);
    checkOutput({tag, ".dREN"},     {31'd0, dREN},    32'd0);
    checkOutput({tag, ".dWEN"},     {31'd0, dWEN},    32'd0);
    checkOutput({tag, ".daddr"},    daddr,            32'd0);
    checkOutput({tag, ".dstore"},   dstore,           32'd0);
  endtask

  // Drives one request, checks hit timing, waits for dhit and the response,
  // then confirms the idle cycle and that every expected transfer happened.
  task automatic applyStimulus(input vec_t v);
    int cyc;
    @(posedge clk); #1;
    for (int k = 0; k < v.nOps; k++) begin
      expOps.push_back('{we: v.opWe[k], addr: v.opAddr[k], data: v.opData[k]});
    end
    dmemREN = v.ren; dmemWEN = v.wen; dmemaddr = v.addr; dmemstore = v.data;
    @(negedge clk);
    checkOutput($sformatf("firstDhit@%h", v.addr), {31'd0, dhit}, {31'd0, v.expHit});
    if (v.expHit) checkOutput($sformatf("noTraffic@%h", v.addr), {30'd0, dREN, dWEN}, 32'd0);
    cyc = 0;
    while (!dhit && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput($sformatf("dhitTimeout@%h", v.addr), {31'd0, dhit}, 32'd1);
    if (v.ren && !v.wen) checkOutput($sformatf("load@%h", v.addr), dmemload, v.expLoad);
    @(posedge clk); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
    @(negedge clk);
    checkOutput("idleDhit", {31'd0, dhit}, 32'd0);
    checkOutput("idleLoad", dmemload, 32'd0);
    checkOutput($sformatf("opsPending@%h", v.addr), expOps.size(), 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    dmemaddr = '0; dmemstore = '0; dload = '0; dwait = 1'b1;
    mem[32'h40] = 32'h0000_AAAA;
    mem[32'h44] = 32'h0000_BBBB;

    // Cold fill of 0x40 into way0 set0, then same-block hit, write hit, re-read.
    addVec(1, 0, 32'h40, 0, 0, 32'h0000_AAAA); addOp(0, 32'h40, 0); addOp(0, 32'h44, 0);
    addVec(1, 0, 32'h44, 0, 1, 32'h0000_BBBB);
    addVec(0, 1, 32'h40, 32'h1234, 1, 0);
    addVec(1, 0, 32'h40, 0, 1, 32'h1234);
    // 0x80 fills way1; touching 0x40 makes way1 the victim for 0xC0 (clean, no writeback).
    addVec(1, 0, 32'h80, 0, 0, defData(32'h80)); addOp(0, 32'h80, 0); addOp(0, 32'h84, 0);
    addVec(1, 0, 32'h40, 0, 1, 32'h1234);
    addVec(1, 0, 32'hC0, 0, 0, defData(32'hC0)); addOp(0, 32'hC0, 0); addOp(0, 32'hC4, 0);
    addVec(0, 1, 32'hC0, 32'hC0DE, 1, 0);
    // 0x80 now evicts dirty way0 (0x40 block) with a two-word writeback first.
    addVec(1, 0, 32'h80, 0, 0, defData(32'h80));
    addOp(1, 32'h40, 32'h1234); addOp(1, 32'h44, 32'hBBBB);
    addOp(0, 32'h80, 0); addOp(0, 32'h84, 0);
    // Set 2: fill way0, hit it, miss goes to way1, way0 data still intact.
    addVec(1, 0, 32'h10, 0, 0, defData(32'h10)); addOp(0, 32'h10, 0); addOp(0, 32'h14, 0);
    addVec(1, 0, 32'h10, 0, 1, defData(32'h10));
    addVec(1, 0, 32'h50, 0, 0, defData(32'h50)); addOp(0, 32'h50, 0); addOp(0, 32'h54, 0);
    addVec(1, 0, 32'h10, 0, 1, defData(32'h10));
    addVec(0, 1, 32'h54, 32'h5454, 1, 0);

    #12;
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].expHit) expHitCnt++;
      applyStimulus(vecs[i]);
    end

    // Flush: only the two dirty way1 frames are written back, then the hit count.
    @(posedge clk); #1;
    expOps.push_back('{we: 1'b1, addr: 32'hC0, data: 32'hC0DE});
    expOps.push_back('{we: 1'b1, addr: 32'hC4, data: defData(32'hC4)});
    expOps.push_back('{we: 1'b1, addr: 32'h50, data: defData(32'h50)});
    expOps.push_back('{we: 1'b1, addr: 32'h54, data: 32'h5454});
    expOps.push_back('{we: 1'b1, addr: 32'h3100, data: expHitCnt});
    halt = 1'b1;
    cyc = 0;
    while (!flushed && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("flushTimeout", {31'd0, flushed}, 32'd1);
    checkOutput("flushOpsPending", expOps.size(), 32'd0);
    @(posedge clk); #1;
    dmemREN = 1'b1; dmemaddr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("doneDhit", {31'd0, dhit}, 32'd0);
      checkOutput("doneFlushed", {31'd0, flushed}, 32'd1);
      checkOutput("doneTraffic", {30'd0, dREN, dWEN}, 32'd0);
    end

    // Reset during the second word of a line fill.
    @(posedge clk); #1;
    dmemREN = 1'b0; halt = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expOps.push_back('{we: 1'b0, addr: 32'h40, data: 32'd0});
    dmemREN = 1'b1; dmemaddr = 32'h40;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(dREN && daddr == 32'h44) && cyc < 50);
    checkOutput("reachLd1", {31'd0, dREN && (daddr == 32'h44)}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midFillReset");
    checkOutput("abortOpsPending", expOps.size(), 32'd0);
    @(posedge clk); #1;
    dmemREN = 1'b0;
    rst_n = 1'b1;
    vecs.delete();
    addVec(1, 0, 32'h40, 0, 0, 32'h1234); addOp(0, 32'h40, 0); addOp(0, 32'h44, 0);
    applyStimulus(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
